// File: rtl/elevator_look_scheduler.sv
// LOOK-order elevator car scheduler: latches floor calls and sequences the car through IDLE/MOVE/DOOR.
// Defining ELEV_ESTOP_EN adds the estop input that freezes motion and door timing.
module elevator_look_scheduler #(
    parameter int FLOORS     = 8,
    parameter int FLOOR_W    = 3,
    parameter int TRAVEL_CYC = 16,
    parameter int DOOR_CYC   = 32
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [FLOORS-1:0]  call_req,
`ifdef ELEV_ESTOP_EN
    input  logic               estop,
`endif
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic [FLOORS-1:0]  pending,
    output logic               idle
);
    localparam int TW = $clog2(TRAVEL_CYC);
    localparam int DW = $clog2(DOOR_CYC);
    localparam logic [TW-1:0]      T_LAST = TW'(TRAVEL_CYC - 1);
    localparam logic [DW-1:0]      D_LAST = DW'(DOOR_CYC - 1);
    localparam logic [FLOOR_W-1:0] TOP    = FLOOR_W'(FLOORS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;

    state_e             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic [FLOORS-1:0]  pend_q, pend_d, clr;
    logic               up_any, dn_any, ahead, behind, halt;

`ifdef ELEV_ESTOP_EN
    assign halt = estop;
`else
    assign halt = 1'b0;
`endif

    function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        onehot    = '0;
        onehot[f] = 1'b1;
    endfunction

    // The end floors admit only one travel direction.
    function automatic logic bound_dir(input logic want, input logic [FLOOR_W-1:0] f);
        if (f == '0)       bound_dir = 1'b1;
        else if (f == TOP) bound_dir = 1'b0;
        else               bound_dir = want;
    endfunction

    always_comb begin
        up_any = 1'b0;
        dn_any = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) > floor_q) up_any = up_any | pend_q[i];
            if (FLOOR_W'(i) < floor_q) dn_any = dn_any | pend_q[i];
        end
        ahead  = dir_q ? up_any : dn_any;
        behind = dir_q ? dn_any : up_any;
    end

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        tcnt_d  = tcnt_q;
        dcnt_d  = dcnt_q;
        clr     = '0;
        case (state_q)
            S_IDLE: begin
                if (!halt) begin
                    if (pend_q[floor_q]) begin
                        state_d = S_DOOR;
                        clr     = onehot(floor_q);
                    end else if (ahead) begin
                        state_d = S_MOVE;
                        dir_d   = bound_dir(dir_q, floor_q);
                    end else if (behind) begin
                        state_d = S_MOVE;
                        dir_d   = bound_dir(!dir_q, floor_q);
                    end
                end
            end
            S_MOVE: begin
                if (!halt) begin
                    if (tcnt_q == T_LAST) begin
                        tcnt_d = '0;
                        if (dir_q && floor_q != TOP)      floor_d = floor_q + FLOOR_W'(1);
                        else if (!dir_q && floor_q != '0) floor_d = floor_q - FLOOR_W'(1);
                        // Arriving at a called floor clears it on the same edge.
                        if (pend_q[floor_d]) begin
                            state_d = S_DOOR;
                            clr     = onehot(floor_d);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            S_DOOR: begin
                clr = onehot(floor_q);
                if (!halt) begin
                    if (dcnt_q == D_LAST) begin
                        dcnt_d = '0;
                        if (ahead) begin
                            state_d = S_MOVE;
                            dir_d   = bound_dir(dir_q, floor_q);
                        end else if (behind) begin
                            state_d = S_MOVE;
                            dir_d   = bound_dir(!dir_q, floor_q);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        pend_d = (pend_q | call_req) & ~clr;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            floor_q <= '0;
            dir_q   <= 1'b1;
            tcnt_q  <= '0;
            dcnt_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            tcnt_q  <= tcnt_d;
            dcnt_q  <= dcnt_d;
            pend_q  <= pend_d;
        end
    end

    assign cur_floor = floor_q;
    assign dir_up    = dir_q;
    assign pending   = pend_q;
    assign moving    = (state_q == S_MOVE);
    assign door_open = (state_q == S_DOOR);
    assign idle      = (state_q == S_IDLE);
endmodule

// File: tb/tb_elevator_look_scheduler.sv
// Self-checking bench for elevator_look_scheduler: vector table, directed corner sequences,
// and randomized calls compared against a countdown-timer reference model of the car.
module tb_elevator_look_scheduler;
    localparam int FL   = 8;
    localparam int FLW  = 3;
    localparam int TCYC = 16;
    localparam int DCYC = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [FL-1:0]  call_req = '0;
    logic           estop = 1'b0;
    logic [FLW-1:0] cur_floor;
    logic           dir_up, moving, door_open, idle;
    logic [FL-1:0]  pending;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_model = 1'b0;

    elevator_look_scheduler #(
        .FLOORS(FL), .FLOOR_W(FLW), .TRAVEL_CYC(TCYC), .DOOR_CYC(DCYC)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .call_req (call_req),
`ifdef ELEV_ESTOP_EN
        .estop    (estop),
`endif
        .cur_floor(cur_floor),
        .dir_up   (dir_up),
        .moving   (moving),
        .door_open(door_open),
        .pending  (pending),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: mode 0 idle, 1 travelling, 2 door open; m_left counts cycles remaining.
    int m_floor;
    bit m_dir;
    int m_mode;
    int m_left;
    bit m_pend[FL];

    function automatic void model_reset();
        m_floor = 0; m_dir = 1'b1; m_mode = 0; m_left = 0;
        for (int f = 0; f < FL; f++) m_pend[f] = 1'b0;
    endfunction

    function automatic bit calls_toward(bit up);
        for (int f = 0; f < FL; f++)
            if (m_pend[f] && (up ? (f > m_floor) : (f < m_floor))) return 1'b1;
        return 1'b0;
    endfunction

    // Keep heading while calls remain ahead, otherwise turn round; 0 if nothing to serve.
    function automatic bit pick_dir();
        if (calls_toward(m_dir)) return 1'b1;
        if (calls_toward(!m_dir)) begin
            m_dir = !m_dir;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_step(logic [FL-1:0] c, logic stop);
        bit was_door = (m_mode == 2);
        int served = -1;
        if (!stop) begin
            case (m_mode)
                0: begin
                    if (m_pend[m_floor]) begin m_mode = 2; m_left = DCYC; end
                    else if (pick_dir()) begin m_mode = 1; m_left = TCYC; end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                        m_left = TCYC;
                        if (m_pend[m_floor]) begin m_mode = 2; m_left = DCYC; end
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (pick_dir()) begin m_mode = 1; m_left = TCYC; end
                        else m_mode = 0;
                    end
                end
            endcase
        end
        if (was_door || m_mode == 2) served = m_floor;
        for (int f = 0; f < FL; f++) m_pend[f] = (m_pend[f] | c[f]) && (f != served);
    endfunction

    function automatic logic [31:0] model_status();
        logic [FL-1:0] p;
        for (int f = 0; f < FL; f++) p[f] = m_pend[f];
        return 32'({FLW'(m_floor), m_dir, m_mode == 1, m_mode == 2, m_mode == 0, p});
    endfunction

    function automatic logic [31:0] dut_status();
        return 32'({cur_floor, dir_up, moving, door_open, idle, pending});
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick(input logic [FL-1:0] c);
        call_req = c;
        @(posedge clk);
        model_step(c, estop);
        #1;
        if (check_model) chk("model_status", dut_status(), model_status());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        call_req = '0;
        estop = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_floor(input int fl, input string name);
        for (int n = 0; n < 300 && int'(cur_floor) != fl; n++) tick('0);
        chk(name, 32'(cur_floor), 32'(fl));
    endtask

    // Waits for the next door opening and checks where and in which direction it happened.
    task automatic wait_door(input int fl, input bit d, input string name);
        int n = 0;
        while (door_open && n < 100) begin tick('0); n++; end
        while (!door_open && n < 400) begin tick('0); n++; end
        chk(name, 32'({door_open, cur_floor, dir_up}), 32'({1'b1, FLW'(fl), d}));
    endtask

    typedef struct {
        logic [FL-1:0] calls;
        int            n;
        int            floor;
        bit            dir, mv, door, idl;
        logic [FL-1:0] pend;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // {calls on first tick, ticks, floor, dir_up, moving, door_open, idle, pending}
        vecs[0]  = '{8'h20, 1,   0, 1, 0, 0, 1, 8'h20};
        vecs[1]  = '{8'h00, 1,   0, 1, 1, 0, 0, 8'h20};
        vecs[2]  = '{8'h00, 79,  4, 1, 1, 0, 0, 8'h20};
        vecs[3]  = '{8'h00, 1,   5, 1, 0, 1, 0, 8'h00};
        vecs[4]  = '{8'h00, 31,  5, 1, 0, 1, 0, 8'h00};
        vecs[5]  = '{8'h00, 1,   5, 1, 0, 0, 1, 8'h00};
        vecs[6]  = '{8'h20, 1,   5, 1, 0, 0, 1, 8'h20};
        vecs[7]  = '{8'h00, 1,   5, 1, 0, 1, 0, 8'h00};
        vecs[8]  = '{8'h00, 32,  5, 1, 0, 0, 1, 8'h00};
        vecs[9]  = '{8'h02, 1,   5, 1, 0, 0, 1, 8'h02};
        vecs[10] = '{8'h00, 1,   5, 0, 1, 0, 0, 8'h02};
        vecs[11] = '{8'h00, 64,  1, 0, 0, 1, 0, 8'h00};
        vecs[12] = '{8'h00, 32,  1, 0, 0, 0, 1, 8'h00};
        vecs[13] = '{8'h81, 2,   1, 0, 1, 0, 0, 8'h81};
        vecs[14] = '{8'h00, 16,  0, 0, 0, 1, 0, 8'h80};
        vecs[15] = '{8'h00, 32,  0, 1, 1, 0, 0, 8'h80};
        vecs[16] = '{8'h00, 112, 7, 1, 0, 1, 0, 8'h00};
        vecs[17] = '{8'h00, 32,  7, 1, 0, 0, 1, 8'h00};

        do_reset();
        chk("reset_state", dut_status(), 32'({FLW'(0), 1'b1, 1'b0, 1'b0, 1'b1, 8'h00}));

        for (int v = 0; v < 18; v++) begin
            tick(vecs[v].calls);
            for (int k = 1; k < vecs[v].n; k++) tick('0);
            chk($sformatf("vec%0d", v), dut_status(),
                32'({FLW'(vecs[v].floor), vecs[v].dir, vecs[v].mv, vecs[v].door,
                     vecs[v].idl, vecs[v].pend}));
        end

        // Asynchronous reset in the middle of travel at floor 3.
        do_reset();
        tick(8'h80);
        wait_floor(3, "rst_reach3");
        tick('0);
        rst = 1'b1;
        #1;
        chk("rst_async", dut_status(), 32'({FLW'(0), 1'b1, 1'b0, 1'b0, 1'b1, 8'h00}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick('0);
        chk("rst_after", dut_status(), 32'({FLW'(0), 1'b1, 1'b0, 1'b0, 1'b1, 8'h00}));

        // LOOK order: calls behind and ahead while travelling up past floor 3.
        do_reset();
        tick(8'h20);
        wait_floor(3, "look_reach3");
        tick(8'h42);
        wait_door(5, 1'b1, "look_door5");
        wait_door(6, 1'b1, "look_door6");
        wait_door(1, 1'b0, "look_door1");

        // Pick-up en route: call at floor 4 made while passing floor 3.
        do_reset();
        tick(8'h80);
        wait_floor(3, "pick_reach3");
        tick(8'h10);
        wait_door(4, 1'b1, "pick_door4");
        chk("pick_pending", 32'(pending), 32'h80);
        wait_door(7, 1'b1, "pick_door7");

`ifdef ELEV_ESTOP_EN
        // Ten stopped cycles mid-travel delay the arrival by exactly ten cycles.
        do_reset();
        tick(8'h04);
        for (int k = 0; k < 6; k++) tick('0);
        estop = 1'b1;
        for (int k = 0; k < 10; k++) tick('0);
        chk("estop_hold", 32'({cur_floor, moving}), 32'({FLW'(0), 1'b1}));
        estop = 1'b0;
        begin
            int n = 0;
            while (!door_open && n < 100) begin tick('0); n++; end
            chk("estop_arrival", 32'(n), 32'd27);
            chk("estop_floor", 32'(cur_floor), 32'd2);
        end
`endif

        // Randomized calls against the reference model.
        do_reset();
        check_model = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            logic [FL-1:0] c;
            c = '0;
            if ($urandom_range(0, 11) == 0) c[$urandom_range(0, FL - 1)] = 1'b1;
            if ($urandom_range(0, 60) == 0) c = FL'($urandom);
`ifdef ELEV_ESTOP_EN
            estop = ($urandom_range(0, 40) == 0);
`endif
            tick(c);
        end
        check_model = 1'b0;
        estop = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
